bus_wait_ctrl: RTL and testbench

BUS_WAIT_CTRL -- requirements
Module: bus_wait_ctrl

---
 rtl/bus_wait_ctrl_pkg.sv | 28 ++
 rtl/bus_wait_ctrl_if.sv | 31 +++
 rtl/bus_wait_ctrl_window_decode.sv | 31 +++
 rtl/bus_wait_ctrl.sv | 109 ++++++++++
 tb/tb_bus_wait_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_wait_ctrl_pkg.sv
// Shared types and defaults for the CPU read wait-state controller.
//   bus_state_e      : controller FSM state encoding
//   DEF_ERROR_DATA   : read data returned when a channel never answers
//   DEF_CHAN_START/END : default inclusive address window per channel (4 x 32)
//   idx_width()      : width of a channel index, never less than 1 bit
package cpu_reg_package;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } bus_state_e;

  localparam logic [31:0] DEF_ERROR_DATA = 32'hDEADBEEF;

  localparam logic [3:0][31:0] DEF_CHAN_START = {
    32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000
  };

  localparam logic [3:0][31:0] DEF_CHAN_END = {
    32'h0000_4FFF, 32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_wait_ctrl_if.sv
// CPU-side bus and downstream read-channel signals of bus_wait_ctrl.
//   address_i/we_i       : CPU address and write enable
//   cpu_halt_o/data_o    : CPU stall and returned read data
//   chan_req_o/ack/data  : per-channel request pulse, data-valid and data
//   timeout_o/err_count_o: timeout pulse and saturating timeout count
// master = CPU/channel side, slave = the controller.
interface bus_wait_ctrl_if #(
  parameter int NumChannels  = 4,
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0]                address_i;
  logic                                   we_i;
  logic                                   cpu_halt_o;
  logic [DataWidth-1:0]                   data_o;
  logic [NumChannels-1:0]                 chan_req_o;
  logic [NumChannels-1:0]                 chan_ack_i;
  logic [NumChannels-1:0][DataWidth-1:0]  chan_data_i;
  logic                                   timeout_o;
  logic [7:0]                             err_count_o;

  modport master (
    output address_i, we_i, chan_ack_i, chan_data_i,
    input  cpu_halt_o, data_o, chan_req_o, timeout_o, err_count_o
  );

  modport slave (
    input  address_i, we_i, chan_ack_i, chan_data_i,
    output cpu_halt_o, data_o, chan_req_o, timeout_o, err_count_o
  );
endinterface

// File: rtl/bus_wait_ctrl_window_decode.sv
// Address window decoder with priority encoder.
//   address : CPU address being decoded
//   hit_any : address falls inside at least one channel window
//   hit_idx : lowest channel index whose window contains address
module bus_window_decode
  import cpu_reg_package::*;
#(
  parameter int NumChannels  = 4,
  parameter int AddressWidth = 32,
  parameter int IdxW         = idx_width(NumChannels),
  parameter logic [NumChannels-1:0][AddressWidth-1:0] ChanStart = DEF_CHAN_START,
  parameter logic [NumChannels-1:0][AddressWidth-1:0] ChanEnd   = DEF_CHAN_END
) (
  input  logic [AddressWidth-1:0] address,
  output logic                    hit_any,
  output logic [IdxW-1:0]         hit_idx
);

  // Scan from the top down so the lowest matching channel is written last.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      if ((address >= ChanStart[k]) && (address <= ChanEnd[k])) begin
        hit_any = 1'b1;
        hit_idx = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/bus_wait_ctrl.sv
// Stalls the CPU on reads to mapped channels until the channel answers or a
// timeout expires, then returns the channel data (or an error pattern).
//   clk_i   : clock, all logic on rising edge
//   reset_i : asynchronous active-high reset
//   bus     : slave side of bus_wait_ctrl_if (CPU bus + channel handshakes)
//
// state  | meaning
// IDLE   | watching for a new read that hits a channel window
// WAIT   | request issued, counting cycles until ack or timeout
// DONE   | one cycle with halt released and read data presented
module bus_wait_ctrl
  import cpu_reg_package::*;
#(
  parameter int NumChannels   = 4,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256,
  parameter logic [DataWidth-1:0] ErrorData = DataWidth'(DEF_ERROR_DATA),
  parameter logic [NumChannels-1:0][AddressWidth-1:0] ChanStart = DEF_CHAN_START,
  parameter logic [NumChannels-1:0][AddressWidth-1:0] ChanEnd   = DEF_CHAN_END
) (
  input logic           clk_i,
  input logic           reset_i,
  bus_wait_ctrl_if.slave bus
);

  localparam int IdxW = idx_width(NumChannels);
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  bus_state_e              state_q;
  logic [AddressWidth-1:0] addr_q;
  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         sel_q;
  logic [DataWidth-1:0]    data_q;
  logic [NumChannels-1:0]  req_q;
  logic                    timeout_q;
  logic [7:0]              err_q;

  logic                    hit_any;
  logic [IdxW-1:0]         hit_idx;
  logic                    read_hit;

  bus_window_decode #(
    .NumChannels (NumChannels),
    .AddressWidth(AddressWidth),
    .IdxW        (IdxW),
    .ChanStart   (ChanStart),
    .ChanEnd     (ChanEnd)
  ) u_decode (
    .address(bus.address_i),
    .hit_any(hit_any),
    .hit_idx(hit_idx)
  );

  // A read access is recognised only when the address changes.
  assign read_hit = (bus.address_i != addr_q) && !bus.we_i && hit_any;

  // Halt must rise in the same cycle the CPU presents the read.
  assign bus.cpu_halt_o  = ((state_q == S_IDLE) && read_hit) || (state_q == S_WAIT);
  assign bus.data_o      = data_q;
  assign bus.chan_req_o  = req_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.err_count_o = err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      req_q     <= '0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      addr_q    <= bus.address_i;
      req_q     <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (read_hit) begin
            state_q <= S_WAIT;
            sel_q   <= hit_idx;
            cnt_q   <= '0;
            req_q   <= NumChannels'(1) << hit_idx;
          end
        end
        S_WAIT: begin
          // Ack is checked first so a last-cycle ack beats the timeout.
          if (bus.chan_ack_i[sel_q]) begin
            data_q  <= bus.chan_data_i[sel_q];
            state_q <= S_DONE;
          end else if (cnt_q == CntLast) begin
            data_q    <= ErrorData;
            timeout_q <= 1'b1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
module tb_bus_wait_ctrl;
  import cpu_reg_package::*;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;
  localparam logic [31:0] ERR_PAT = 32'hDEADBEEF;

  // ch3 overlaps the upper half of ch2; the overlap belongs to ch2.
  localparam logic [3:0][31:0] WIN_START = {32'h3800, 32'h3000, 32'h2000, 32'h1000};
  localparam logic [3:0][31:0] WIN_END   = {32'h4FFF, 32'h3FFF, 32'h2FFF, 32'h1FFF};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   err_model = 0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  bus_wait_ctrl_if #(.NumChannels(NC), .AddressWidth(AW), .DataWidth(DW)) bus ();

  bus_wait_ctrl #(
    .NumChannels  (NC),
    .AddressWidth (AW),
    .DataWidth    (DW),
    .TimeoutCycles(T),
    .ChanStart    (WIN_START),
    .ChanEnd      (WIN_END)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_chan(input logic [31:0] a);
    for (int k = 0; k < NC; k++)
      if (a >= WIN_START[k] && a <= WIN_END[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] rand_hit_addr();
    int ch;
    logic [31:0] a;
    do begin
      ch = $urandom_range(0, NC - 1);
      a  = $urandom_range(int'(WIN_START[ch]), int'(WIN_END[ch]));
    end while (a == prev_addr);
    return a;
  endfunction

  // Read transaction: channel acks in WAIT cycle d (d >= T means never).
  task automatic do_read(input logic [31:0] addr, input int d,
                         input logic [31:0] ack_data, input bit noise);
    int ch, cyc, halt_cnt, req_cnt, other;
    logic [3:0] req_first, onehot;
    logic [31:0] exp_data;
    bit done, acked;
    ch = exp_chan(addr);
    onehot = 4'b0001 << ch;
    acked = (d < T);
    exp_data = acked ? ack_data : ERR_PAT;
    bus.address_i = addr;
    bus.we_i = 1'b0;
    bus.chan_ack_i = '0;
    prev_addr = addr;
    cyc = 0; halt_cnt = 0; req_cnt = 0; req_first = '0; done = 0;
    while (!done && cyc < T + 8) begin
      #1;
      if (cyc > 0 && !bus.cpu_halt_o) done = 1;
      else begin
        if (bus.cpu_halt_o) halt_cnt++;
        if (bus.chan_req_o != '0) req_cnt++;
        if (cyc == 1) req_first = bus.chan_req_o;
        @(posedge clk); #1;
        cyc++;
        bus.chan_ack_i = '0;
        if (cyc - 1 == d) begin
          bus.chan_ack_i[ch] = 1'b1;
          bus.chan_data_i[ch] = ack_data;
        end else begin
          bus.chan_data_i[ch] = $urandom;
        end
        if (noise) begin
          other = $urandom_range(0, NC - 1);
          if (other != ch && $urandom_range(0, 1) == 1) begin
            bus.chan_ack_i[other] = 1'b1;
            bus.chan_data_i[other] = $urandom;
          end
        end
      end
    end
    if (!done) chk("read_completion", 0, 1);
    if (!acked) err_model = (err_model < 255) ? err_model + 1 : 255;
    chk("halt_cycles", halt_cnt, acked ? d + 2 : T + 1);
    chk("req_first", req_first, onehot);
    chk("req_cycles", req_cnt, 1);
    chk("done_data", bus.data_o, exp_data);
    chk("timeout_pulse", bus.timeout_o, !acked);
    chk("err_count", bus.err_count_o, err_model);
    bus.chan_ack_i = '0;
    @(posedge clk); #2;
    chk("no_retrigger", bus.cpu_halt_o, 0);
    chk("timeout_one_cycle", bus.timeout_o, 0);
    chk("data_hold", bus.data_o, exp_data);
  endtask

  // Writes or unmapped reads must never halt or request.
  task automatic do_nohit(input logic [31:0] addr, input logic we);
    logic seen_halt, seen_req;
    bus.address_i = addr;
    bus.we_i = we;
    prev_addr = addr;
    seen_halt = 0; seen_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      seen_halt |= bus.cpu_halt_o;
      seen_req  |= (bus.chan_req_o != '0);
      @(posedge clk); #1;
    end
    chk("nohit_halt", seen_halt, 0);
    chk("nohit_req", seen_req, 0);
    bus.we_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_halt, seen_req;
    logic [31:0] a;
    rst = 1'b1;
    bus.address_i = '0;
    bus.we_i = 1'b0;
    bus.chan_ack_i = '0;
    bus.chan_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halt", bus.cpu_halt_o, 0);
    chk("rst_req", bus.chan_req_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_err", bus.err_count_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_read(32'h3100, 4, 32'h0000_1234, 0);   // ch2, ack in 5th WAIT cycle
    do_read(32'h1100, 99, 32'h0, 0);          // ch0 timeout
    do_read(32'h4100, 6, 32'hC3C3_0003, 1);   // ch3 with stray acks elsewhere
    do_read(32'h3900, 2, 32'h0000_2222, 1);   // overlap resolves to ch2
    do_read(32'h2100, 0, 32'hAAAA_0001, 0);   // ack with the request
    do_read(32'h1200, T - 1, 32'hBBBB_0002, 0); // ack on the timeout cycle
    do_nohit(32'h1300, 1'b1);                 // write into ch0 window
    do_nohit(32'h5500, 1'b0);                 // unmapped read

    for (int i = 0; i < 40; i++) begin
      do a = $urandom_range(0, 32'h5FFF); while (a == prev_addr);
      if (exp_chan(a) < 0 || $urandom_range(0, 4) == 0)
        do_nohit(a, (exp_chan(a) >= 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      else
        do_read(a, $urandom_range(0, T + 2), $urandom, 1);
    end

    // Reset in the middle of a WAIT, then a late ack.
    bus.address_i = 32'h2200;
    prev_addr = 32'h2200;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.address_i = '0;
    #1;
    chk("midrst_halt", bus.cpu_halt_o, 0);
    chk("midrst_req", bus.chan_req_o, 0);
    chk("midrst_data", bus.data_o, 0);
    chk("midrst_timeout", bus.timeout_o, 0);
    chk("midrst_err", bus.err_count_o, 0);
    err_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.chan_ack_i = 4'b0010;
    bus.chan_data_i[1] = 32'hCAFE_F00D;
    seen_halt = 0; seen_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      seen_halt |= bus.cpu_halt_o;
      seen_req  |= (bus.chan_req_o != '0);
      @(posedge clk); #1;
      bus.chan_ack_i = '0;
    end
    chk("late_ack_halt", seen_halt, 0);
    chk("late_ack_req", seen_req, 0);
    chk("late_ack_data", bus.data_o, 0);
    chk("late_ack_err", bus.err_count_o, 0);

    // Drive enough timeouts to saturate the error counter.
    for (int i = 0; i < 300; i++)
      do_read(rand_hit_addr(), T + 1, 32'h0, 0);
    chk("err_saturated", bus.err_count_o, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
